// File: rtl/skylark_pkg.sv
// skylark_pkg -- shared decode-stage types and constants.
//   imm_format_t : immediate-format select for the extend unit
//   result_src_t : write-back result source select
//   dctl_state_t : decode controller FSM state
//   dctl_ctrl_t  : bundle of per-instruction control signals
//   OPC_*        : base-ISA major opcodes recognised by the decoder
package skylark_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_format_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } dctl_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        imm_format_t imm_format;
        logic        utype;
        logic        imm_used;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        result_src_t result_src;
    } dctl_ctrl_t;

    // All-zero control bundle: what the datapath sees for a bubble or a
    // rejected instruction.
    localparam dctl_ctrl_t CTRL_NONE = '0;

    // LUI and AUIPC share the U-type immediate handled outside the extend unit.
    function automatic logic is_utype(input logic [6:0] opcode);
        return (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/decode_controller_if.sv
// decode_controller_if -- Fetch->Decode handshake and decode-stage control bus.
//   Fetch side : InstrF, PCF, ValidF (to controller), ReadyF (from controller)
//   Hazard side: StallD, FlushD (to controller)
//   Decode side: InstrD, PCD, ValidD, ImmFormatD, UTypeD, ImmUsedD, RegWriteD,
//                MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, TrapD
//   modport master : pipeline environment (drives F inputs, stall, flush)
//   modport slave  : the decode controller
interface decode_controller_if;

    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        ValidF;
    logic        ReadyF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        ValidD;
    logic [1:0]  ImmFormatD;
    logic        UTypeD;
    logic        ImmUsedD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        BranchD;
    logic        JumpD;
    logic        ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic        TrapD;

    modport master (
        output InstrF, PCF, ValidF, StallD, FlushD,
        input  ReadyF, InstrD, PCD, ValidD, ImmFormatD, UTypeD, ImmUsedD,
               RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, TrapD
    );

    modport slave (
        input  InstrF, PCF, ValidF, StallD, FlushD,
        output ReadyF, InstrD, PCD, ValidD, ImmFormatD, UTypeD, ImmUsedD,
               RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ResultSrcD, TrapD
    );

endinterface

// File: rtl/main_decoder.sv
// main_decoder -- purely combinational opcode classifier.
//   opcode  in  7 : InstrD[6:0]
//   ctrl    out   : control bundle for the recognised instruction class
//   illegal out 1 : opcode is not one of the supported classes
module main_decoder
    import skylark_pkg::*;
(
    input  logic [6:0] opcode,
    output dctl_ctrl_t ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        unique case (opcode)
            OPC_LOAD: begin
                ctrl.imm_format = IMM_I;
                ctrl.imm_used   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OPC_OP_IMM: begin
                ctrl.imm_format = IMM_I;
                ctrl.imm_used   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                ctrl.imm_format = IMM_S;
                ctrl.imm_used   = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.imm_format = IMM_B;
                ctrl.imm_used   = 1'b1;
                ctrl.branch     = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_format = IMM_J;
                ctrl.imm_used   = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OPC_JALR: begin
                ctrl.imm_format = IMM_I;
                ctrl.imm_used   = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OPC_LUI, OPC_AUIPC: begin
                // The U immediate bypasses the extend unit, so ImmUsed stays 0
                // and the format select is left at its neutral value.
                ctrl.utype      = is_utype(opcode);
                ctrl.reg_write  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_controller.sv
// decode_controller -- decode-stage controller.
// Owns the Fetch->Decode pipeline register, classifies the registered opcode,
// and handles stall, flush and illegal-instruction trapping so the decode
// datapath only ever sees a live instruction or an all-zero control bundle.
//   clk     in  1 : single clock, rising edge
//   reset_n in  1 : synchronous, active-low reset
//   bus     slave : decode_controller_if (F handshake, stall/flush, D outputs)
module decode_controller
    import skylark_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
)(
    input  logic clk,
    input  logic reset_n,
    decode_controller_if.slave bus
);

    dctl_state_t state_reg,  state_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_d_reg,    pc_d_next;
    logic        valid_d_reg, valid_d_next;
    logic        trap_d_reg,  trap_d_next;

    dctl_ctrl_t  ctrl_raw;
    dctl_ctrl_t  ctrl_gated;
    logic        illegal;
    logic        ready_f;

    main_decoder u_main_decoder (
        .opcode  (instr_d_reg[6:0]),
        .ctrl    (ctrl_raw),
        .illegal (illegal)
    );

    // Held low during reset so fetch never sees a transfer that the
    // register is about to discard.
    assign ready_f = reset_n && (state_reg == RUN) && !bus.StallD;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= RUN;
            instr_d_reg <= RESET_INSTR;
            pc_d_reg    <= '0;
            valid_d_reg <= 1'b0;
            trap_d_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            instr_d_reg <= instr_d_next;
            pc_d_reg    <= pc_d_next;
            valid_d_reg <= valid_d_next;
            trap_d_reg  <= trap_d_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        instr_d_next = instr_d_reg;
        pc_d_next    = pc_d_reg;
        valid_d_next = valid_d_reg;
        trap_d_next  = 1'b0;

        if (bus.FlushD) begin
            // A redirect always wins: it kills the D contents, leaves TRAP,
            // and pre-empts a trap on an illegal instruction sitting in D.
            state_next   = RUN;
            instr_d_next = RESET_INSTR;
            pc_d_next    = '0;
            valid_d_next = 1'b0;
        end else if (state_reg == TRAP) begin
            // Parked until the redirect arrives; stall has no meaning here.
            valid_d_next = 1'b0;
        end else if (valid_d_reg && illegal) begin
            // Raise the trap and scrub D so nothing downstream acts on it.
            state_next   = TRAP;
            trap_d_next  = 1'b1;
            instr_d_next = RESET_INSTR;
            pc_d_next    = '0;
            valid_d_next = 1'b0;
        end else if (bus.StallD) begin
            valid_d_next = valid_d_reg;
        end else if (bus.ValidF) begin
            instr_d_next = bus.InstrF;
            pc_d_next    = bus.PCF;
            valid_d_next = 1'b1;
        end else begin
            // Bubble: InstrD keeps its stale value, only ValidD drops.
            valid_d_next = 1'b0;
        end
    end

    assign ctrl_gated = (valid_d_reg && !illegal) ? ctrl_raw : CTRL_NONE;

    assign bus.ReadyF     = ready_f;
    assign bus.InstrD     = instr_d_reg;
    assign bus.PCD        = pc_d_reg;
    assign bus.ValidD     = valid_d_reg;
    assign bus.TrapD      = trap_d_reg;
    assign bus.ImmFormatD = ctrl_gated.imm_format;
    assign bus.UTypeD     = ctrl_gated.utype;
    assign bus.ImmUsedD   = ctrl_gated.imm_used;
    assign bus.RegWriteD  = ctrl_gated.reg_write;
    assign bus.MemWriteD  = ctrl_gated.mem_write;
    assign bus.BranchD    = ctrl_gated.branch;
    assign bus.JumpD      = ctrl_gated.jump;
    assign bus.ALUSrcD    = ctrl_gated.alu_src;
    assign bus.ResultSrcD = ctrl_gated.result_src;

endmodule

// File: tb/tb_decode_controller.sv
// tb_decode_controller -- directed self-checking bench for decode_controller.
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// i.e. well away from the next active edge.
module tb_decode_controller;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    decode_controller_if bus ();

    decode_controller #(.RESET_INSTR(32'h0000_0013)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.ValidF = v;
        bus.InstrF = instr;
        bus.PCF    = pc;
        $display("txn: ValidF=%0b InstrF=%h PCF=%h StallD=%0b FlushD=%0b",
                 v, instr, pc, bus.StallD, bus.FlushD);
    endtask

    // Checks the whole decoded control bundle against hand-computed values.
    task automatic check_ctrl(input string tag, input logic [1:0] fmt, input logic ut,
                              input logic iu, input logic rw, input logic mw,
                              input logic br, input logic jp, input logic as,
                              input logic [1:0] rs);
        check({tag, ".ImmFormatD"}, 32'(bus.ImmFormatD), 32'(fmt));
        check({tag, ".UTypeD"},     32'(bus.UTypeD),     32'(ut));
        check({tag, ".ImmUsedD"},   32'(bus.ImmUsedD),   32'(iu));
        check({tag, ".RegWriteD"},  32'(bus.RegWriteD),  32'(rw));
        check({tag, ".MemWriteD"},  32'(bus.MemWriteD),  32'(mw));
        check({tag, ".BranchD"},    32'(bus.BranchD),    32'(br));
        check({tag, ".JumpD"},      32'(bus.JumpD),      32'(jp));
        check({tag, ".ALUSrcD"},    32'(bus.ALUSrcD),    32'(as));
        check({tag, ".ResultSrcD"}, 32'(bus.ResultSrcD), 32'(rs));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ValidD"}, 32'(bus.ValidD), 32'd0);
        check({tag, ".TrapD"},  32'(bus.TrapD),  32'd0);
        check({tag, ".InstrD"}, bus.InstrD,      32'h0000_0013);
        check({tag, ".PCD"},    bus.PCD,         32'h0);
        check_ctrl(tag, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.StallD = 1'b0;
        bus.FlushD = 1'b0;
        drive_f(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check_reset_state("reset");
        reset_n = 1'b1;
        #1;
        check("reset.ReadyF", 32'(bus.ReadyF), 32'd1);

        // addi x1,x2,-4
        drive_f(1'b1, 32'hFFC10093, 32'h100);
        tick();
        check("addi.ValidD", 32'(bus.ValidD), 32'd1);
        check("addi.InstrD", bus.InstrD, 32'hFFC10093);
        check("addi.PCD",    bus.PCD,    32'h100);
        check_ctrl("addi", 2'b00, 0, 1, 1, 0, 0, 0, 1, 2'b00);

        // back-to-back stream
        drive_f(1'b1, 32'h00112223, 32'h104);
        tick();
        check("sw.PCD", bus.PCD, 32'h104);
        check_ctrl("sw", 2'b01, 0, 1, 0, 1, 0, 0, 1, 2'b00);

        drive_f(1'b1, 32'hFE000EE3, 32'h108);
        tick();
        check_ctrl("beq", 2'b10, 0, 1, 0, 0, 1, 0, 0, 2'b00);

        // stall 3 cycles with jal waiting on F
        bus.StallD = 1'b1;
        drive_f(1'b1, 32'h0080006F, 32'h10C);
        #1;
        check("stall.ReadyF", 32'(bus.ReadyF), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d.InstrD", i), bus.InstrD, 32'hFE000EE3);
            check($sformatf("stall%0d.PCD", i),    bus.PCD,    32'h108);
            check($sformatf("stall%0d.ValidD", i), 32'(bus.ValidD),  32'd1);
            check($sformatf("stall%0d.BranchD", i), 32'(bus.BranchD), 32'd1);
            check($sformatf("stall%0d.ReadyF", i), 32'(bus.ReadyF),  32'd0);
        end
        bus.StallD = 1'b0;
        #1;
        check("release.ReadyF", 32'(bus.ReadyF), 32'd1);
        tick();
        check("jal.InstrD", bus.InstrD, 32'h0080006F);
        check("jal.PCD",    bus.PCD,    32'h10C);
        check_ctrl("jal", 2'b11, 0, 1, 1, 0, 0, 1, 0, 2'b10);

        // bubble: InstrD stale, controls gated
        drive_f(1'b0, 32'h0, 32'h0);
        tick();
        check("bubble.ValidD", 32'(bus.ValidD), 32'd0);
        check("bubble.InstrD", bus.InstrD, 32'h0080006F);
        check_ctrl("bubble", 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // lw, add, lui, jalr
        drive_f(1'b1, 32'h00412083, 32'h200);
        tick();
        check_ctrl("lw", 2'b00, 0, 1, 1, 0, 0, 0, 1, 2'b01);
        drive_f(1'b1, 32'h00208133, 32'h204);
        tick();
        check_ctrl("add", 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        drive_f(1'b1, 32'h123450B7, 32'h208);
        tick();
        check_ctrl("lui", 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00);
        drive_f(1'b1, 32'h000080E7, 32'h20C);
        tick();
        check_ctrl("jalr", 2'b00, 0, 1, 1, 0, 0, 1, 1, 2'b10);

        // stall and flush together: flush wins
        bus.StallD = 1'b1;
        bus.FlushD = 1'b1;
        drive_f(1'b1, 32'h00112223, 32'h210);
        tick();
        bus.StallD = 1'b0;
        bus.FlushD = 1'b0;
        check("sflush.ValidD", 32'(bus.ValidD), 32'd0);
        check("sflush.InstrD", bus.InstrD, 32'h0000_0013);
        check("sflush.PCD",    bus.PCD,    32'h0);

        // illegal in D, flushed before it can trap
        drive_f(1'b1, 32'h00000073, 32'h300);
        tick();
        check("ill.ValidD", 32'(bus.ValidD), 32'd1);
        check_ctrl("ill", 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        bus.FlushD = 1'b1;
        drive_f(1'b0, 32'h0, 32'h0);
        tick();
        bus.FlushD = 1'b0;
        #1;
        check("illflush.TrapD",  32'(bus.TrapD),  32'd0);
        check("illflush.ReadyF", 32'(bus.ReadyF), 32'd1);
        check("illflush.ValidD", 32'(bus.ValidD), 32'd0);

        // illegal in D traps
        drive_f(1'b1, 32'h00000073, 32'h304);
        tick();
        drive_f(1'b1, 32'hFFC10093, 32'h308);
        tick();
        check("trap.TrapD",  32'(bus.TrapD),  32'd1);
        check("trap.ValidD", 32'(bus.ValidD), 32'd0);
        check("trap.InstrD", bus.InstrD, 32'h0000_0013);
        check("trap.ReadyF", 32'(bus.ReadyF), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("trapwait%0d.TrapD", i),  32'(bus.TrapD),  32'd0);
            check($sformatf("trapwait%0d.ValidD", i), 32'(bus.ValidD), 32'd0);
            check($sformatf("trapwait%0d.ReadyF", i), 32'(bus.ReadyF), 32'd0);
        end
        bus.FlushD = 1'b1;
        tick();
        bus.FlushD = 1'b0;
        #1;
        check("trapexit.ReadyF", 32'(bus.ReadyF), 32'd1);
        tick();
        check("trapexit.ValidD", 32'(bus.ValidD), 32'd1);
        check("trapexit.InstrD", bus.InstrD, 32'hFFC10093);

        // reset while in TRAP
        drive_f(1'b1, 32'h00000073, 32'h400);
        tick();
        drive_f(1'b0, 32'h0, 32'h0);
        tick();
        check("trap2.TrapD", 32'(bus.TrapD), 32'd1);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check_reset_state("rsttrap");
        check("rsttrap.ReadyF", 32'(bus.ReadyF), 32'd1);

        // reset at the edge where a trap would be raised
        drive_f(1'b1, 32'h00000073, 32'h500);
        tick();
        drive_f(1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("rstpend.TrapD",  32'(bus.TrapD),  32'd0);
        check("rstpend.ReadyF", 32'(bus.ReadyF), 32'd1);
        tick();
        check("rstpend2.TrapD", 32'(bus.TrapD), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
